// File: rtl/posicion_gen.sv
// posicion_gen: multi-channel position sequencer.
// A shared prescaler produces a base tick. Each channel divides that tick by
// its own speed value and, on every step, advances its position according to
// its mode: toggle, wrap-up, wrap-down or bounce. Positions always stay within
// 0..MAXPOS. The tick only gates updates; it is never used as a clock.
module posicion_gen #(
  parameter int CLK_DIV = 25000000,
  parameter int CH      = 4,
  parameter int PW      = 4,
  parameter int SW      = 3,
  parameter int MAXPOS  = 2**PW-1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH-1:0]      enable,
  input  logic [CH*SW-1:0]   speed,
  input  logic [CH*2-1:0]    mode,
  output logic [CH*PW-1:0]   posicion,
  output logic [CH-1:0]      step,
  output logic               tick
);

  localparam int              PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PW-1:0]   MAXP     = PW'(MAXPOS);
  localparam logic [PW-1:0]   POS_ONE  = PW'(1);
  localparam logic [SW-1:0]   CNT_ONE  = SW'(1);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  // Shared prescaler and registered base tick
  logic [PRE_W-1:0] r_pre;
  logic             r_tick;

  // Per-channel state
  logic [SW-1:0]    r_cnt  [CH];
  logic [PW-1:0]    r_pos  [CH];
  logic [CH-1:0]    r_dir;   // 1 = moving up (bounce mode only)
  logic [CH-1:0]    r_step;

  // Per-channel combinational next state
  logic [SW-1:0]    w_spd     [CH];
  logic [1:0]       w_mode    [CH];
  logic [CH-1:0]    w_fire;
  logic [SW-1:0]    w_cnt_nxt [CH];
  logic [PW:0]      w_adv     [CH];

  // Next {dir, position} for one step of a channel in the given mode.
  // Only bounce mode looks at or changes the direction bit; every branch
  // lands inside 0..MAXPOS when the current position is in range.
  function automatic logic [PW:0] f_advance(input logic [1:0]    md,
                                            input logic [PW-1:0] pos,
                                            input logic          dir);
    logic [PW-1:0] p;
    logic          d;
    p = pos;
    d = dir;
    case (md)
      MODE_TOGGLE: p = (pos == '0) ? MAXP : '0;
      MODE_UP:     p = (pos == MAXP) ? '0 : pos + POS_ONE;
      MODE_DOWN:   p = (pos == '0) ? MAXP : pos - POS_ONE;
      default: begin
        if (dir) begin
          if (pos == MAXP) begin
            p = MAXP - POS_ONE;
            d = 1'b0;
          end else begin
            p = pos + POS_ONE;
          end
        end else begin
          if (pos == '0) begin
            p = POS_ONE;
            d = 1'b1;
          end else begin
            p = pos - POS_ONE;
          end
        end
      end
    endcase
    return {d, p};
  endfunction

  // Prescaler: count 0..CLK_DIV-1 and flag the terminal count as next cycle's tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_pre == PRE_LAST);
      r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_ONE;
    end
  end

  // Channel decode: divider compare, next divider count and next position
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < CH; i++) begin
      w_spd[i]     = speed[i*SW +: SW];
      w_mode[i]    = mode[i*2 +: 2];
      w_cnt_nxt[i] = r_cnt[i];
      w_adv[i]     = f_advance(w_mode[i], r_pos[i], r_dir[i]);
      if (!enable[i]) begin
        // Disabled channels restart their divider from zero on re-enable
        w_cnt_nxt[i] = '0;
      end else if (r_tick) begin
        // Compare with >= so a speed lowered below cnt fires on this tick
        // rather than letting cnt run around the counter range
        if (r_cnt[i] >= w_spd[i]) begin
          w_fire[i]    = 1'b1;
          w_cnt_nxt[i] = '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Channel registers: position and step pulse update together on a fire
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir  <= '1;
      r_step <= '0;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
        r_pos[i] <= '0;
      end
    end else begin
      r_step <= w_fire;
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_fire[i]) begin
          r_pos[i] <= w_adv[i][PW-1:0];
          r_dir[i] <= w_adv[i][PW];
        end
      end
    end
  end

  // Output packing of the registered channel state
  always_comb begin
    posicion = '0;
    for (int i = 0; i < CH; i++) begin
      posicion[i*PW +: PW] = r_pos[i];
    end
  end

  assign step = r_step;
  assign tick = r_tick;

endmodule

// File: tb/tb_posicion_gen.sv
// Testbench for posicion_gen with CLK_DIV=4, CH=2, PW=3, SW=3, MAXPOS=5.
// Expected step events come from a table; a negedge monitor pops them from
// per-channel queues as the DUT reports steps.
module tb_posicion_gen;
  localparam int CLK_DIV = 4;
  localparam int CH      = 2;
  localparam int PW      = 3;
  localparam int SW      = 3;
  localparam int MAXPOS  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     enable;
  logic [CH*SW-1:0]  speed;
  logic [CH*2-1:0]   mode;
  logic [CH*PW-1:0]  posicion;
  logic [CH-1:0]     step;
  logic              tick;

  posicion_gen #(
    .CLK_DIV(CLK_DIV), .CH(CH), .PW(PW), .SW(SW), .MAXPOS(MAXPOS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .speed(speed), .mode(mode),
    .posicion(posicion), .step(step), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            sec;
    int            ch;
    logic [PW-1:0] pos;
    int            gap;   // cycles since previous step on that channel, 0 = unchecked
  } vec_t;

  typedef struct {
    logic [PW-1:0] pos;
    int            gap;
  } exp_t;

  vec_t          vt[$];
  exp_t          q0[$];
  exp_t          q1[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_step [CH];
  bit            mon_on = 1'b0;
  logic [PW-1:0] prev_pos [CH];

  function automatic logic [PW-1:0] pos_of(input int k);
    return posicion[k*PW +: PW];
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic addv(input int s, input int c, input int p, input int g);
    vec_t v;
    v.sec = s;
    v.ch  = c;
    v.pos = PW'(p);
    v.gap = g;
    vt.push_back(v);
  endtask

  task automatic push_sec(input int s);
    exp_t e;
    foreach (vt[i]) begin
      if (vt[i].sec == s) begin
        e.pos = vt[i].pos;
        e.gap = vt[i].gap;
        if (vt[i].ch == 0) q0.push_back(e);
        else               q1.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d/%0d expected steps still pending after %0d cycles, required 0",
               name, q0.size(), q1.size(), budget);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic wait_tick(input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < budget);
    check(name, int'(tick === 1'b1), 1);
  endtask

  // Scoreboard monitor: every step must match the next queued expectation,
  // and positions must never move without a step
  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (mon_on) begin
      for (int k = 0; k < CH; k++) begin
        if (step[k] === 1'b1) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_step ch%0d: got step with pos %0d, expected no step (t=%0t)",
                     k, pos_of(k), $time);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("step_pos_ch%0d", k), int'(pos_of(k)), int'(e.pos));
            if (e.gap != 0)
              check($sformatf("step_gap_ch%0d", k), cyc - last_step[k], e.gap);
          end
          last_step[k] = cyc;
        end else if (pos_of(k) !== prev_pos[k]) begin
          checks++;
          errors++;
          $display("FAIL pos_hold_ch%0d: got %0d, expected %0d (no step)", k, pos_of(k), prev_pos[k]);
        end
      end
    end
    for (int k = 0; k < CH; k++) prev_pos[k] = pos_of(k);
  end

  initial begin
    int b[11];
    int ticks_seen;
    int n;
    bit seen;

    // Expected step table: section, channel, position, gap
    for (int i = 1; i <= 6; i++) addv(1, 0, i % 6, (i == 1) ? 0 : 4);
    b = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    for (int i = 0; i < 11; i++) addv(2, 0, b[i], (i == 0) ? 0 : 12);
    addv(3, 1, 5, 0); addv(3, 1, 0, 8); addv(3, 1, 5, 8);
    addv(4, 1, 4, 8); addv(4, 1, 3, 8); addv(4, 1, 2, 8);
    addv(5, 0, 2, 0);
    addv(6, 0, 3, 0); addv(6, 0, 4, 4); addv(6, 0, 5, 4); addv(6, 0, 4, 4); addv(6, 0, 3, 4);
    addv(7, 0, 1, 0); addv(7, 0, 2, 4); addv(7, 0, 3, 4);

    // Reset held for 3 edges, then tick on cycles 4, 8, 12
    rst_n  = 1'b0;
    enable = '0;
    speed  = '0;
    mode   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_posicion", int'(posicion), 0);
    check("reset_step", int'(step), 0);
    check("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("tick_cycle%0d", c), int'(tick), int'(c % CLK_DIV == 0));
    end
    mon_on = 1'b1;

    // ch0 wrap-up at speed 0; ch1 stays disabled
    push_sec(1);
    speed[2:0] = 3'd0;
    mode[1:0]  = 2'b01;
    enable[0]  = 1'b1;
    wait_drain(100, "drain_wrap_up");
    enable[0] = 1'b0;
    check("ch1_idle_pos", int'(pos_of(1)), 0);

    // ch0 bounce at speed 2
    push_sec(2);
    speed[2:0] = 3'd2;
    mode[1:0]  = 2'b11;
    enable[0]  = 1'b1;
    wait_drain(400, "drain_bounce");
    enable[0] = 1'b0;

    // ch1 toggle at speed 1, then wrap-down from 5
    push_sec(3);
    speed[5:3] = 3'd1;
    mode[3:2]  = 2'b00;
    enable[1]  = 1'b1;
    wait_drain(200, "drain_toggle");
    mode[3:2] = 2'b10;
    push_sec(4);
    wait_drain(200, "drain_wrap_down");
    enable[1] = 1'b0;

    // ch0 speed 7: run 5 ticks, disable, re-enable; divider must restart
    speed[2:0] = 3'd7;
    mode[1:0]  = 2'b01;
    wait_tick(20, "sync_tick_a");
    @(negedge clk);
    enable[0] = 1'b1;
    ticks_seen = 0;
    n = 0;
    while (ticks_seen < 5 && n < 60) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) ticks_seen++;
    end
    check("ticks_before_disable", ticks_seen, 5);
    @(negedge clk);
    enable[0] = 1'b0;
    repeat (3) wait_tick(20, "idle_tick");
    check("pos_after_disable", int'(pos_of(0)), 1);
    push_sec(5);
    wait_tick(20, "sync_tick_b");
    @(negedge clk);
    enable[0] = 1'b1;
    ticks_seen = 0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (step[0] === 1'b1) seen = 1'b1;
      else if (tick === 1'b1) ticks_seen++;
    end
    check("reenable_step_seen", int'(seen), 1);
    check("reenable_ticks_to_step", ticks_seen, 8);

    // ch0 bounce at speed 0 up to 5 and back to 3, then reset mid-bounce
    push_sec(6);
    speed[2:0] = 3'd0;
    mode[1:0]  = 2'b11;
    wait_drain(100, "drain_bounce_pre_reset");
    check("pos_before_reset", int'(pos_of(0)), 3);
    rst_n  = 1'b0;
    mon_on = 1'b0;
    @(negedge clk);
    check("midreset_pos0", int'(pos_of(0)), 0);
    check("midreset_pos1", int'(pos_of(1)), 0);
    check("midreset_step", int'(step), 0);
    check("midreset_tick", int'(tick), 0);
    rst_n = 1'b1;
    push_sec(7);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 1) mon_on = 1'b1;
      if (step[0] === 1'b1) seen = 1'b1;
    end
    check("first_step_after_reset", n, CLK_DIV + 1);
    wait_drain(100, "drain_after_reset");
    enable = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posicion_gen.md
POSICION_GEN -- requirements
Module: posicion_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 25000000, clk cycles per base tick (>=2).
REQ-002 SHALL have parameter CH, default 4, number of independent position channels (>=1).
REQ-003 SHALL have parameter PW, default 4, position width per channel in bits.
REQ-004 SHALL have parameter SW, default 3, speed field width per channel in bits.
REQ-005 SHALL have parameter MAXPOS, default 2**PW-1, highest legal position (1..2**PW-1).
REQ-006 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port enable  input  CH  per-channel run enable.
REQ-009 SHALL have port speed  input  CH*SW  per-channel divider; channel i at [i*SW +: SW].
REQ-010 SHALL have port mode  input  CH*2  per-channel mode; 00 toggle, 01 wrap-up, 10 wrap-down, 11 bounce.
REQ-011 SHALL have port posicion  output  CH*PW  registered position; channel i at [i*PW +: PW].
REQ-012 SHALL have port step  output  CH  registered one-cycle pulse per channel position update.
REQ-013 SHALL have port tick  output  1  registered base-tick pulse.

Function
REQ-014 SHALL run one prescaler counting 0..CLK_DIV-1, wrapping to 0; tick is high for exactly the one cycle after the prescaler holds CLK_DIV-1, so one tick per CLK_DIV cycles.
REQ-015 SHALL NOT derive any clock; tick is used only as a clock enable.
REQ-016 SHALL keep, per channel, a divider count cnt of SW bits.
REQ-017 SHALL, on a clock edge with tick=1 and enable[i]=1, step channel i when cnt>=speed[i] and clear cnt; otherwise it increments cnt. Step period is speed+1 ticks; speed=0 steps on every tick.
REQ-018 SHALL compare against speed sampled at each tick; lowering speed below cnt causes a step on the next tick, with no wrap-through.
REQ-019 SHALL, while enable[i]=0, hold cnt[i] at 0, hold posicion[i], keep step[i]=0, and retain the bounce direction.
REQ-020 SHALL update posicion[i] on the same edge that registers step[i]=1; step[i] is high for exactly that following cycle.
REQ-021 SHALL, in mode 00 (toggle), move from 0 to MAXPOS on a step, and from any nonzero position to 0.
REQ-022 SHALL, in mode 01 (wrap-up), step pos+1, with MAXPOS going to 0.
REQ-023 SHALL, in mode 10 (wrap-down), step pos-1, with 0 going to MAXPOS.
REQ-024 SHALL, in mode 11 (bounce), keep a per-channel dir bit:
- moving up, MAXPOS goes to MAXPOS-1 and dir flips down;
- moving down, 0 goes to 1 and dir flips up;
- otherwise pos moves by +/-1 per dir.
REQ-025 SHALL keep posicion within 0..MAXPOS in every mode and across mode changes; a mode change takes effect on the next step with no reset of cnt or position.
REQ-026 SHALL make channels fully independent; they share only the prescaler and tick.

Reset
REQ-027 SHALL, on a rising edge with rst_n=0, clear the prescaler, tick, all cnt, all posicion, and all step, and set all dir to up.
REQ-028 SHALL take reset precedence over tick and enable on the same edge, including mid-count and mid-bounce.
REQ-029 SHALL assert the first tick after reset release CLK_DIV cycles after the first edge with rst_n=1.

Verification (CLK_DIV=4, CH=2, PW=3, SW=3, MAXPOS=5)
REQ-030 SHALL be verified by: rst_n=0 for 3 edges -> posicion=0, step=0, tick=0; after release, tick pulses on cycles 4, 8, 12, ...
REQ-031 SHALL be verified by: ch0 enable=1, speed=0, mode=01 -> posicion0 = 0,1,2,3,4,5,0 changing every 4 cycles, with step0 pulses coincident; ch1 enable=0 stays 0.
REQ-032 SHALL be verified by: ch0 speed=2, mode=11 -> one step per 12 cycles; sequence 0,1,2,3,4,5,4,3,2,1,0,1.
REQ-033 SHALL be verified by: ch1 mode=00, speed=1 -> posicion1 = 0,5,0,5 every 8 cycles; then switch to mode=10 at pos 5 -> 4,3,...
REQ-034 SHALL be verified by: speed=7, drop enable after 5 ticks, re-enable -> no step for a full 8 ticks after re-enable; position unchanged.
REQ-035 SHALL be verified by: rst_n=0 for one edge mid-bounce at pos 3 moving down -> pos 0, dir up; next steps 1, 2, 3.
